// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key receiver: frame FSM states, FIFO entry
// layout and the scan-code prefix bytes.
package ps2_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StData   = 2'd1,
      StParity = 2'd2,
      StStop   = 2'd3
   } ps2_state_e;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_entry_t;

   localparam logic [7:0]  PS2_EXT_PREFIX   = 8'hE0;
   localparam logic [7:0]  PS2_BREAK_PREFIX = 8'hF0;
   localparam int unsigned PS2_ENTRY_W      = $bits(ps2_entry_t);

   // Odd parity: data bits plus the parity bit must hold an odd number of ones.
   function automatic logic ps2_parity_ok(input logic [7:0] i_data, input logic i_par);
      return ^{i_data, i_par};
   endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Single-clock FIFO for decoded key entries. DEPTH must be a power of two, at least 2.
// A push into a full FIFO is dropped and flagged, unless a pop frees the slot that cycle.
module ps2_sync_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 10
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic             o_ovf
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_ovf;

   logic w_empty;
   logic w_full;
   logic w_do_pop;
   logic w_do_push;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CW'(DEPTH));
   assign w_do_pop  = i_pop && !w_empty;
   assign w_do_push = i_push && (!w_full || w_do_pop);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         r_ovf <= i_push && !w_do_push;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_valid = !w_empty;
   assign o_ovf   = r_ovf;

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronise, filter, deframe, decode E0/F0 prefixes, queue entries.
// Define PS2_TYPEMATIC_FILTER_EN to drop auto-repeated makes of the currently held key.
module ps2_key_receiver
   import ps2_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 4,
   parameter int unsigned TIMEOUT_CYC = 100000,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic       Clk,
   input  logic       rst,
   input  logic       PS2Clk,
   input  logic       PS2Data,
   input  logic       keyReady,
   output logic       keyValid,
   output logic [7:0] keyCode,
   output logic       keyBreak,
   output logic       keyExt,
   output logic       keyPressed,
   output logic       parityErr,
   output logic       frameErr,
   output logic       fifoOvf
);

   localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TCW = $clog2(TIMEOUT_CYC + 1);

   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_data_sync;
   logic                   r_clk_filt;
   logic [FCW-1:0]         r_filt_cnt;
   ps2_state_e             r_state;
   logic [2:0]             r_bit_cnt;
   logic [7:0]             r_shift;
   logic                   r_par;
   logic [TCW-1:0]         r_to_cnt;
   logic                   r_ext;
   logic                   r_brk;
   logic                   r_pressed;
   logic                   r_last_ext;
   logic [7:0]             r_last_code;
   logic                   r_parity_err;
   logic                   r_frame_err;

   logic       w_clk_s;
   logic       w_data_s;
   logic       w_filt_done;
   logic       w_fall;
   logic       w_timeout;
   logic       w_stop_sample;
   logic       w_par_ok;
   logic       w_byte_ok;
   logic       w_discard;
   logic       w_is_prefix;
   logic       w_same_make;
   logic       w_repeat;
   logic       w_push;
   ps2_entry_t w_entry;
   ps2_entry_t w_head;
   logic       w_valid;
   logic       w_ovf;

   assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
   assign w_data_s = r_data_sync[SYNC_STAGES-1];

   // PS/2 lines idle high, so the synchronisers come out of reset at 1.
   always_ff @(posedge Clk) begin
      if (rst) begin
         r_clk_sync  <= '1;
         r_data_sync <= '1;
      end else begin
         r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], PS2Clk};
         r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], PS2Data};
      end
   end

   assign w_filt_done = (w_clk_s != r_clk_filt) && (r_filt_cnt == FCW'(FILTER_LEN - 1));
   assign w_fall      = w_filt_done && !w_clk_s;

   always_ff @(posedge Clk) begin
      if (rst) begin
         r_clk_filt <= 1'b1;
         r_filt_cnt <= '0;
      end else if (w_clk_s == r_clk_filt) begin
         r_filt_cnt <= '0;
      end else if (w_filt_done) begin
         r_clk_filt <= w_clk_s;
         r_filt_cnt <= '0;
      end else begin
         r_filt_cnt <= r_filt_cnt + FCW'(1);
      end
   end

   assign w_timeout = (r_state != StIdle) && !w_fall && (r_to_cnt == TCW'(TIMEOUT_CYC - 1));

   always_ff @(posedge Clk) begin
      if (rst) begin
         r_state   <= StIdle;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_par     <= 1'b0;
         r_to_cnt  <= '0;
      end else if (w_timeout) begin
         r_state  <= StIdle;
         r_to_cnt <= '0;
      end else begin
         if (w_fall || (r_state == StIdle)) r_to_cnt <= '0;
         else                               r_to_cnt <= r_to_cnt + TCW'(1);
         if (w_fall) begin
            case (r_state)
               StIdle: begin
                  if (!w_data_s) begin
                     r_state   <= StData;
                     r_bit_cnt <= '0;
                  end
               end
               StData: begin
                  r_shift   <= {w_data_s, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) r_state <= StParity;
               end
               StParity: begin
                  r_par   <= w_data_s;
                  r_state <= StStop;
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   assign w_stop_sample = w_fall && (r_state == StStop);
   assign w_par_ok      = ps2_parity_ok(r_shift, r_par);
   assign w_byte_ok     = w_stop_sample && w_par_ok && w_data_s;
   assign w_discard     = w_timeout || (w_stop_sample && !(w_par_ok && w_data_s));
   assign w_is_prefix   = (r_shift == PS2_EXT_PREFIX) || (r_shift == PS2_BREAK_PREFIX);
   assign w_same_make   = ({r_ext, r_shift} == {r_last_ext, r_last_code});

`ifdef PS2_TYPEMATIC_FILTER_EN
   // Armed by a pushed make, disarmed by any pushed break.
   logic r_rep_armed;

   always_ff @(posedge Clk) begin
      if (rst)         r_rep_armed <= 1'b0;
      else if (w_push) r_rep_armed <= !r_brk;
   end

   assign w_repeat = !r_brk && r_rep_armed && w_same_make;
`else
   assign w_repeat = 1'b0;
`endif

   assign w_push  = w_byte_ok && !w_is_prefix && !w_repeat;
   assign w_entry = '{ext: r_ext, brk: r_brk, code: r_shift};

   always_ff @(posedge Clk) begin
      if (rst) begin
         r_ext       <= 1'b0;
         r_brk       <= 1'b0;
         r_pressed   <= 1'b0;
         r_last_ext  <= 1'b0;
         r_last_code <= '0;
      end else if (w_discard) begin
         r_ext <= 1'b0;
         r_brk <= 1'b0;
      end else if (w_byte_ok) begin
         if (r_shift == PS2_EXT_PREFIX) begin
            r_ext <= 1'b1;
         end else if (r_shift == PS2_BREAK_PREFIX) begin
            r_brk <= 1'b1;
         end else begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
            if (w_push && r_brk) begin
               if (w_same_make) r_pressed <= 1'b0;
            end else if (w_push) begin
               r_pressed   <= 1'b1;
               r_last_ext  <= r_ext;
               r_last_code <= r_shift;
            end
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (rst) begin
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_parity_err <= w_stop_sample && !w_par_ok;
         r_frame_err  <= w_timeout || (w_stop_sample && w_par_ok && !w_data_s);
      end
   end

   ps2_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PS2_ENTRY_W)
   ) u_fifo (
      .i_clk   (Clk),
      .i_rst   (rst),
      .i_push  (w_push),
      .i_data  (w_entry),
      .i_pop   (keyReady),
      .o_data  (w_head),
      .o_valid (w_valid),
      .o_ovf   (w_ovf)
   );

   // Head fields are forced to 0 while empty so stale RAM never reaches the pins.
   assign keyValid   = w_valid;
   assign keyCode    = w_valid ? w_head.code : 8'h00;
   assign keyBreak   = w_valid && w_head.brk;
   assign keyExt     = w_valid && w_head.ext;
   assign keyPressed = r_pressed;
   assign parityErr  = r_parity_err;
   assign frameErr   = r_frame_err;
   assign fifoOvf    = w_ovf;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Self-checking bench for ps2_key_receiver: directed scenarios plus a randomized key stream
// checked against a scan-code decoding model. Honours PS2_TYPEMATIC_FILTER_EN.
module tb_ps2_key_receiver;

   localparam int unsigned TO   = 300;
   localparam int unsigned HALF = 8;
`ifdef PS2_TYPEMATIC_FILTER_EN
   localparam int unsigned N21 = 2;
   localparam bit          TYPEMATIC = 1'b1;
`else
   localparam int unsigned N21 = 4;
   localparam bit          TYPEMATIC = 1'b0;
`endif

   logic       Clk = 1'b0;
   logic       rst = 1'b1;
   logic       PS2Clk = 1'b1;
   logic       PS2Data = 1'b1;
   logic       keyReady = 1'b1;
   logic       keyValid;
   logic [7:0] keyCode;
   logic       keyBreak;
   logic       keyExt;
   logic       keyPressed;
   logic       parityErr;
   logic       frameErr;
   logic       fifoOvf;

   always #5 Clk = ~Clk;

   ps2_key_receiver #(
      .SYNC_STAGES (2),
      .FILTER_LEN  (4),
      .TIMEOUT_CYC (TO),
      .FIFO_DEPTH  (4)
   ) dut (
      .Clk        (Clk),
      .rst        (rst),
      .PS2Clk     (PS2Clk),
      .PS2Data    (PS2Data),
      .keyReady   (keyReady),
      .keyValid   (keyValid),
      .keyCode    (keyCode),
      .keyBreak   (keyBreak),
      .keyExt     (keyExt),
      .keyPressed (keyPressed),
      .parityErr  (parityErr),
      .frameErr   (frameErr),
      .fifoOvf    (fifoOvf)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   int         n_perr   = 0;
   int         n_ferr   = 0;
   int         n_ovf    = 0;
   logic [9:0] got_q[$];
   logic [9:0] exp_q[$];

   // Reference model state: pending prefixes, last make, held key, repeat guard.
   bit         m_ext, m_brk, m_pressed, m_armed;
   logic [8:0] m_last;
   int         m_perr;

   always @(posedge Clk) begin
      if (!rst) begin
         if (keyValid && keyReady) got_q.push_back({keyExt, keyBreak, keyCode});
         if (parityErr) n_perr <= n_perr + 1;
         if (frameErr)  n_ferr <= n_ferr + 1;
         if (fifoOvf)   n_ovf  <= n_ovf + 1;
      end
   end

   function automatic logic [9:0] ent(input bit e, input bit b, input logic [7:0] c);
      return {e, b, c};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic ps2_bit(input logic d);
      PS2Data = d;
      wait_clk(HALF);
      PS2Clk = 1'b0;
      wait_clk(HALF);
      PS2Clk = 1'b1;
   endtask

   task automatic send_range(input logic [10:0] bits, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) ps2_bit(bits[i]);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
      send_range({stop, par, b, 1'b0}, 0, 10);
      PS2Data = 1'b1;
      wait_clk(20);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, ~^b, 1'b1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wait_clk(3);
      rst = 1'b0;
      wait_clk(2);
      got_q.delete();
   endtask

   function automatic void model_byte(input logic [7:0] b);
      bit drop;
      if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         drop = TYPEMATIC && !m_brk && m_armed && ({m_ext, b} == m_last);
         if (!drop) begin
            exp_q.push_back(ent(m_ext, m_brk, b));
            if (m_brk) begin
               if ({m_ext, b} == m_last) m_pressed = 1'b0;
               m_armed = 1'b0;
            end else begin
               m_pressed = 1'b1;
               m_last    = {m_ext, b};
               m_armed   = 1'b1;
            end
         end
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endfunction

   logic [7:0] codes [4] = '{8'h1C, 8'h32, 8'h21, 8'h75};
   logic [7:0] rb;
   int         p0, f0, o0;

   initial begin
      do_reset();
      chk("reset_outputs", {keyValid, keyCode, keyBreak, keyExt, keyPressed, parityErr,
                            frameErr, fifoOvf}, 32'h0);

      // Single make 0x17
      send_byte(8'h17);
      chk("r20_count", got_q.size(), 1);
      chk("r20_entry", got_q[0], ent(0, 0, 8'h17));
      chk("r20_pressed", keyPressed, 1);
      chk("r20_drained", keyValid, 0);

      // Repeated make then release
      do_reset();
      send_byte(8'h17); send_byte(8'h17); send_byte(8'h17);
      send_byte(8'hF0); send_byte(8'h17);
      chk("r21_count", got_q.size(), N21);
      chk("r21_first", got_q[0], ent(0, 0, 8'h17));
      chk("r21_last", got_q[got_q.size()-1], ent(0, 1, 8'h17));
      chk("r21_pressed", keyPressed, 0);

      // Extended make and extended break
      got_q.delete();
      send_byte(8'hE0); send_byte(8'h75);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      chk("r22_count", got_q.size(), 2);
      chk("r22_make", got_q[0], ent(1, 0, 8'h75));
      chk("r22_break", got_q[1], ent(1, 1, 8'h75));

      // Parity and stop errors; a pending F0 must not survive a discarded frame
      got_q.delete();
      p0 = n_perr; f0 = n_ferr;
      send_byte(8'hF0);
      send_frame(8'h16, 1'b1, 1'b1);
      chk("r23_perr", n_perr - p0, 1);
      send_frame(8'h16, 1'b0, 1'b0);
      chk("r23_ferr", n_ferr - f0, 1);
      chk("r23_none", got_q.size(), 0);
      send_frame(8'h16, 1'b0, 1'b1);
      chk("r23_count", got_q.size(), 1);
      chk("r23_entry", got_q[0], ent(0, 0, 8'h16));

      // Clock stall after four data bits
      do_reset();
      f0 = n_ferr;
      send_range({1'b1, ~^8'h16, 8'h16, 1'b0}, 0, 4);
      wait_clk(TO + 60);
      chk("r24_timeout_ferr", n_ferr - f0, 1);
      chk("r24_timeout_none", got_q.size(), 0);
      send_byte(8'h16);
      chk("r24_after_to", got_q[0], ent(0, 0, 8'h16));

      // Reset mid-frame; the all-ones tail must not start a new frame
      got_q.delete();
      p0 = n_perr; f0 = n_ferr;
      send_range({1'b1, 1'b1, 8'hFF, 1'b0}, 0, 4);
      rst = 1'b1;
      wait_clk(2);
      chk("r24_rst_outputs", {keyValid, keyCode, keyBreak, keyExt, keyPressed, parityErr,
                              frameErr, fifoOvf}, 32'h0);
      rst = 1'b0;
      wait_clk(2);
      send_range({1'b1, 1'b1, 8'hFF, 1'b0}, 5, 10);
      wait_clk(TO + 20);
      chk("r24_rst_none", got_q.size(), 0);
      chk("r24_rst_errs", (n_perr - p0) + (n_ferr - f0), 0);
      send_byte(8'h16);
      chk("r24_rst_next", got_q[0], ent(0, 0, 8'h16));

      // Overflow with consumer stalled
      do_reset();
      keyReady = 1'b0;
      o0 = n_ovf;
      for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i));
      chk("r25_ovf", n_ovf - o0, 1);
      chk("r25_valid", keyValid, 1);
      chk("r25_head", keyCode, 8'h11);
      keyReady = 1'b1;
      wait_clk(10);
      chk("r25_count", got_q.size(), 4);
      for (int i = 0; i < 4; i++) chk("r25_order", got_q[i], ent(0, 0, 8'h11 + 8'(i)));
      chk("r25_empty", keyValid, 0);

      // Randomized key stream against the model
      do_reset();
      exp_q.delete();
      m_ext = 0; m_brk = 0; m_pressed = 0; m_armed = 0; m_last = '0; m_perr = 0;
      p0 = n_perr;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 9))
            0: begin send_byte(8'hE0); model_byte(8'hE0); end
            1, 2: begin send_byte(8'hF0); model_byte(8'hF0); end
            3: begin
               rb = codes[$urandom_range(0, 3)];
               send_frame(rb, ~(~^rb), 1'b1);
               m_ext = 0; m_brk = 0; m_perr++;
            end
            default: begin
               rb = codes[$urandom_range(0, 3)];
               send_byte(rb);
               model_byte(rb);
            end
         endcase
      end
      chk("rnd_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) chk("rnd_entry", got_q[i], exp_q[i]);
      chk("rnd_pressed", keyPressed, m_pressed);
      chk("rnd_perr", n_perr - p0, m_perr);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
